// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the NOP encoding used for squashed/empty IF/ID slots, and the default
// reset fetch address.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    // Word address 0xC00 corresponds to byte address 0x3000.
    localparam logic [29:0] DEFAULT_RESET_PC = 30'h0000_0C00;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_ifid_reg.sv
// IF/ID pipeline register. Loads {pc, instruction, valid} on load_i; when
// squash_i accompanies a load the instruction becomes a NOP and valid drops,
// but the PC is still captured so decode sees where the bubble came from.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [31:2] pc_i,
    input  logic [31:0] ir_i,
    output logic [31:2] pc_o,
    output logic [31:0] ir_o,
    output logic        valid_o
);

    logic [31:2] pc_q;
    logic [31:0] ir_q;
    logic        valid_q;

    // Register update: reset to an empty slot, otherwise load on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            ir_q    <= squash_i ? NOP_INSTR : ir_i;
            valid_q <= ~squash_i;
        end
    end

    assign pc_o    = pc_q;
    assign ir_o    = ir_q;
    assign valid_o = valid_q;

endmodule : ifid_reg

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the fetch PC, a one-word hold buffer for
// instructions that arrive while decode is stalled, and the IF/ID register.
// Optional macro FETCH_DELAY_SLOT_EN: when defined, the transfer that
// coincides with a taken redirect is kept (delay slot) instead of squashed.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] npc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:2] pc_if,
    output logic [31:2] pc_id,
    output logic [31:0] ir_id,
    output logic        valid_id,
    output logic        fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:2]  pc_if_q, pc_if_d;
    logic [31:0]  hold_ir_q, hold_ir_d;
    logic         transfer;
    logic         squash;
    logic [31:0]  xfer_ir;

    // State, fetch PC and hold buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_if_q   <= RESET_PC;
            hold_ir_q <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            pc_if_q   <= pc_if_d;
            hold_ir_q <= hold_ir_d;
        end
    end

    // Next-state logic: a transfer (retire or hold release) advances the PC
    // to npc; an ack under stall parks the word in the hold buffer instead.
    always_comb begin
        state_d    = state_q;
        pc_if_d    = pc_if_q;
        hold_ir_d  = hold_ir_q;
        transfer   = 1'b0;
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req   = 1'b1;
                fetch_busy = ~imem_ack;
                if (imem_ack) begin
                    if (stall) begin
                        hold_ir_d = imem_rdata;
                        state_d   = HOLD;
                    end else begin
                        transfer = 1'b1;
                        pc_if_d  = npc;
                    end
                end
            end
            HOLD: begin
                // imem_ack is ignored here; no request is outstanding.
                if (!stall) begin
                    transfer = 1'b1;
                    pc_if_d  = npc;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Word handed to IF/ID: straight from memory on retire, from the hold
    // buffer on release.
    assign xfer_ir = (state_q == HOLD) ? hold_ir_q : imem_rdata;

`ifdef FETCH_DELAY_SLOT_EN
    // Delay-slot instruction after a taken branch executes normally.
    logic unused_redirect;
    assign unused_redirect = redirect;
    assign squash          = 1'b0;
`else
    // The sequential instruction after a taken branch is wrong-path.
    assign squash = redirect & transfer;
`endif

    ifid_reg #(
        .RESET_PC (RESET_PC)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (transfer),
        .squash_i (squash),
        .pc_i     (pc_if_q),
        .ir_i     (xfer_ir),
        .pc_o     (pc_id),
        .ir_o     (ir_id),
        .valid_o  (valid_id)
    );

    assign pc_if     = pc_if_q;
    assign imem_addr = pc_if_q;

endmodule : fetch_pc_unit

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It issues word fetches to instruction memory with a req/ack handshake. It also holds a fetched instruction while decode is stalled and squashes wrong-path instructions on redirect. It sits directly upstream of the next-PC block: it supplies `pc_if` (fetch PC) and `pc_id` (decode PC) to that block and loads the resulting `npc` when a fetch retires.

## Interface
Parameters:
- `RESET_PC`, default 30'h0000_0C00: word address (byte 0x3000) loaded on reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `npc`  in  [31:2]  next word PC from next-PC logic (combinational from `pc_if`/`pc_id`).
- `redirect`  in  1  branch/jump taken in ID this cycle.
- `stall`  in  1  decode stall from hazard unit; IF/ID must not change.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  [31:2]  word address; equals `pc_if`.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  [31:0]  instruction word.
- `pc_if`  out  [31:2]  current fetch PC.
- `pc_id`  out  [31:2]  PC of instruction in IF/ID.
- `ir_id`  out  [31:0]  instruction in IF/ID.
- `valid_id`  out  1  IF/ID holds a real instruction.
- `fetch_busy`  out  1  fetch outstanding with no ack this cycle; to hazard unit.

## Operation
- **States:**
  - FETCH: `imem_req`=1.
  - HOLD: `imem_req`=0; `hold_ir` is valid.
- **FETCH, `imem_ack`=1, `stall`=0 ("retire"):**
  - IF/ID <= {`pc_if`, `imem_rdata`, valid}.
  - `pc_if` <= `npc`.
  - Stay in FETCH.
- **FETCH, `imem_ack`=1, `stall`=1:**
  - `hold_ir` <= `imem_rdata`.
  - IF/ID unchanged, `pc_if` unchanged.
  - Go to HOLD.
- **FETCH, `imem_ack`=0:** nothing changes; `fetch_busy`=1.
- **HOLD, `stall`=0:**
  - IF/ID <= {`pc_if`, `hold_ir`, valid}.
  - `pc_if` <= `npc`.
  - Go to FETCH.
- **HOLD, `stall`=1:** stay in HOLD; IF/ID and `pc_if` unchanged.
- **Squash:** applies only when `redirect`=1 in a transfer cycle (retire or HOLD release). See Configuration.
  - A squashed transfer writes `ir_id`=32'h0 (NOP) and `valid_id`=0.
  - `pc_id` still takes `pc_if`.
  - `pc_if` still takes `npc`, which is the branch/jump target.
- **Precedence:** `stall`=1 overrides `redirect`; `redirect` is ignored unless a transfer occurs.
- `imem_ack` outside FETCH is ignored.
- **Arithmetic:** all PCs are 30-bit word addresses; no increment is done here. Sequential +1 comes from `npc`, and wrap at 30'h3FFF_FFFF is natural overflow in that logic.

## Timing
- **Reset values:**
  - state=FETCH
  - `pc_if`=RESET_PC, `pc_id`=RESET_PC
  - `ir_id`=32'h0, `valid_id`=0
  - `imem_req`=1 in the first cycle after `rst` deasserts
  - `fetch_busy`=1
- **Reset mid-fetch:** an ack in a cycle with `rst`=1 is discarded. Instruction memory must accept `imem_req` restarting at RESET_PC.
- **Latency:** a zero-wait memory (ack in the same cycle as req) sustains 1 instruction per cycle. With N wait cycles, an instruction reaches IF/ID N+1 cycles after `pc_if` is presented.
- `imem_addr` is stable while `imem_req`=1 and no ack has arrived.
- `npc` is sampled only on transfer edges.
- `fetch_busy` is combinational: FETCH & !`imem_ack`.

## Configuration
- `FETCH_DELAY_SLOT_EN`
  - **Defined:** MIPS delay-slot semantics. The transfer coinciding with `redirect` is not squashed; the sequential instruction after the branch executes.
  - **Undefined:** that transfer is squashed (NOP, `valid_id`=0), giving one bubble per taken branch/jump.

## Structure
- Shared package `fetch_pkg`:
  - state enum {FETCH, HOLD}
  - `NOP_INSTR`=32'h0
  - default RESET_PC constant
- One natural sub-module: `ifid_reg`, the IF/ID register with load enable, squash input and reset to {RESET_PC, NOP, 0}.
- FSM, hold buffer and PC register stay in the top module.

## Test plan
- **Reset, zero-wait:** release `rst` with `imem_ack` tied 1 and `npc`=`pc_if`+1 → `imem_addr` 0xC00, 0xC01, 0xC02 on consecutive cycles; `pc_id`/`ir_id` trail by one cycle; `valid_id`=1 from the second cycle.
- **Wait states:** ack 2 cycles after req → `fetch_busy`=1 for 2 cycles, `imem_addr` held at 0xC00, IF/ID loads only on the ack edge.
- **Stall on ack:** `stall`=1 at ack of 0xC01 for 3 cycles → state HOLD, `imem_req`=0, IF/ID keeps 0xC00. On release, IF/ID={0xC01, held word} and `pc_if`=`npc`.
- **Redirect to target 0x0D00:**
  - Without the macro: IF/ID gets NOP with `valid_id`=0, next fetch address 0x0D00.
  - With `FETCH_DELAY_SLOT_EN`: delay-slot word is valid in IF/ID, next fetch 0x0D00.
- **Stall+redirect together, then reset:** `stall`=1 with `redirect`=1 → no change. `rst` during a pending ack → ack ignored, `pc_if`=0xC00, `valid_id`=0 next cycle.
